clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Runtime-programmable integer clock divider with a ratio-change controller; the divided output has as close to 50% duty as possible for both odd and even ratios.
- The controller accepts a new divide ratio over a valid/ready handshake and range-checks it.
- An accepted ratio takes effect only at a divided-period boundary, so the output never produces a runt pulse.
- Sits between the configuration register block and clock-consuming logic that needs a retunable low-rate clock.

Parameters:
- DIV_W, 8, width of the ratio field and counters.
- DIV_DEFAULT, 7, ratio loaded at reset; must lie in [2, DIV_MAX].
- DIV_MAX, 255, largest accepted ratio; must be at most 2^DIV_W-1.

Ports:
- clk_i  in  1  source clock.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  divider run enable.
- cfg_valid_i  in  1  new ratio offered.
- cfg_div_i  in  DIV_W  offered ratio N.
- cfg_ready_o  out  1  controller can accept a ratio.
- cfg_err_o  out  1  one-cycle pulse: offered ratio rejected.
- busy_o  out  1  accepted ratio is waiting for a period boundary.
- div_cur_o  out  DIV_W  ratio currently in effect.
- tick_o  out  1  one-cycle pulse on the first clk_i cycle of each divided period.
- clk_div_o  out  1  divided clock.

Behaviour:
- Reset (asynchronous, all flops including the negedge flop):
  - div_cur_o = DIV_DEFAULT; posedge count cnt_p = 0; FSM = IDLE.
  - cfg_ready_o = 1; cfg_err_o = 0; busy_o = 0; tick_o = 0; clk_div_o = 0.
- Counter:
  - While en_i = 1, cnt_p counts 0..N-1 on posedge clk_i and wraps to 0 (N = div_cur_o).
  - While en_i = 0, cnt_p is forced to 0, clk_div_o = 0 and tick_o = 0.
  - tick_o is asserted when en_i = 1 and cnt_p = 0.
- Output generation:
  - Even N: hi_p = (cnt_p < N/2), registered on posedge; clk_div_o = hi_p. Result is N/2 source cycles high.
  - Odd N: hi_p = (cnt_p <= (N-1)/2), registered on posedge; hi_n = hi_p resampled on negedge clk_i; clk_div_o = hi_p AND hi_n. Result is N/2 source cycles high (half-cycle resolution) and N/2 low.
  - The odd/even choice is taken from div_cur_o bit 0.
- FSM: two states, IDLE and PEND.
  - IDLE:
    - cfg_ready_o = 1.
    - Handshake occurs when cfg_valid_i & cfg_ready_o are both 1 on a rising edge.
    - If 2 <= cfg_div_i <= DIV_MAX: capture it into n_new and go to PEND.
    - Otherwise: pulse cfg_err_o on the next cycle, stay in IDLE, leave div_cur_o unchanged.
  - PEND:
    - cfg_ready_o = 0, busy_o = 1; cfg_valid_i is ignored (the requester holds it).
    - On the edge where en_i = 1 and cnt_p = N-1: cnt_p becomes 0, div_cur_o becomes n_new, FSM returns to IDLE. The new period starts immediately with the new ratio.
    - If en_i = 0 while in PEND: div_cur_o becomes n_new on the next edge and FSM returns to IDLE.
- Boundary conditions:
  - Equal ratio: n_new equal to div_cur_o still passes through PEND; the output is unaffected.
  - N = 2: the change applies at the end of every second cycle; the output toggles every clk_i cycle.
  - en_i deasserted mid-period: the output drops low immediately after the register update; on re-enable the first period is full-length.
  - rst_i mid-PEND: the pending ratio is discarded and DIV_DEFAULT is restored.
- Latency:
  - Handshake to div_cur_o update is 1..N cycles when enabled, 1 cycle when disabled.
  - cfg_err_o follows the rejecting handshake by 1 cycle.

Optional Feature:
- CLK_DIV_PERIOD_CNT_EN
- Defined:
  - Adds output port period_cnt_o, 16 bits.
  - period_cnt_o increments on every tick_o and wraps from 0xFFFF to 0.
  - It clears to 0 on reset and on each ratio application.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, en_i=1, no configuration -> div_cur_o=7; clk_div_o period is 7 clk_i cycles and high for 3.5 cycles; tick_o pulses every 7 cycles.
- Offer cfg_div_i=4 in IDLE while cnt_p=2 -> busy_o=1 until the edge where cnt_p=6; then div_cur_o=4; period is 4 cycles, high 2; no period shorter than 4 cycles appears.
- Offer cfg_div_i=1, then 0, then (with DIV_MAX=200) 201 -> cfg_err_o pulses once per offer; div_cur_o stays unchanged; busy_o stays 0.
- In PEND, hold cfg_valid_i=1 with cfg_div_i=9 -> not accepted until IDLE; accepted after the first change applies; ends with div_cur_o=9.
- en_i=0 during PEND with ratio 5 pending -> div_cur_o=5 one cycle later, clk_div_o=0; re-enable gives a 5-cycle period, high 2.5 cycles.
- Assert rst_i mid-PEND (asynchronously, between edges) -> all outputs return to reset values immediately and the pending ratio is lost; with CLK_DIV_PERIOD_CNT_EN, period_cnt_o=0.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//   Runtime-programmable integer clock divider with a ratio-change controller.
//   A new ratio is taken over a valid/ready handshake and range-checked.
//   An accepted ratio is parked until the current divided period ends, so the
//   output never shows a runt pulse. Odd ratios get half-cycle duty
//   resolution from a negedge resample of the high phase.
//
//   Optional build macro: CLK_DIV_PERIOD_CNT_EN adds period_cnt_o, a 16-bit
//   count of divided periods. It clears on reset and on every ratio change.
//
// Ports
//   clk_i        source clock
//   rst_i        asynchronous active-high reset
//   en_i         divider run enable
//   cfg_valid_i  new ratio offered
//   cfg_div_i    offered ratio N
//   cfg_ready_o  controller can accept a ratio (IDLE)
//   cfg_err_o    one-cycle pulse: offered ratio rejected
//   busy_o       accepted ratio waiting for a period boundary
//   div_cur_o    ratio currently in effect
//   tick_o       pulse on the first clk_i cycle of each divided period
//   period_cnt_o divided-period count (CLK_DIV_PERIOD_CNT_EN only)
//   clk_div_o    divided clock
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 7,
    parameter int DIV_MAX     = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             busy_o,
    output logic [DIV_W-1:0] div_cur_o,
    output logic             tick_o,
`ifdef CLK_DIV_PERIOD_CNT_EN
    output logic [15:0]      period_cnt_o,
`endif
    output logic             clk_div_o
);

    localparam logic [DIV_W-1:0] LP_DEF = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] LP_MAX = DIV_W'(DIV_MAX);
    localparam logic [DIV_W-1:0] LP_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_cur;
    logic [DIV_W-1:0] r_n_new;
    logic             r_run;    // en_i seen at the previous edge
    logic             r_ready;
    logic             r_busy;
    logic             r_err;
    logic             r_tick;
    logic             r_hi_p;
    logic             r_hi_n;

    logic             w_wrap;
    logic             w_hs;
    logic             w_ok;
    logic             w_apply;
    logic [DIV_W-1:0] w_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_thr;

    assign w_wrap  = en_i & r_run & (r_cnt == r_div_cur - LP_ONE);
    assign w_hs    = cfg_valid_i & r_ready;
    assign w_ok    = (cfg_div_i >= LP_MIN) && (cfg_div_i <= LP_MAX);
    // Pending ratio lands at the period boundary, or at once when stopped.
    assign w_apply = (r_state == S_PEND) & (w_wrap | ~en_i);
    assign w_div_nxt = w_apply ? r_n_new : r_div_cur;

    // The first enabled edge after a stop (or reset) restarts at phase 0
    // so the first period after re-enable is full length.
    always_comb begin
        w_cnt_nxt = '0;
        if (en_i && r_run && !w_wrap)
            w_cnt_nxt = r_cnt + LP_ONE;
    end

    // High-phase threshold ceil(N/2): N/2 for even, (N+1)/2 for odd, i.e.
    // cnt <= (N-1)/2 for odd ratios.
    assign w_thr = (w_div_nxt >> 1) + {{(DIV_W-1){1'b0}}, w_div_nxt[0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div_cur <= LP_DEF;
            r_n_new   <= LP_DEF;
            r_run     <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_tick    <= 1'b0;
            r_hi_p    <= 1'b0;
        end else begin
            r_run     <= en_i;
            r_cnt     <= w_cnt_nxt;
            r_div_cur <= w_div_nxt;
            r_tick    <= en_i & (w_cnt_nxt == '0);
            r_hi_p    <= en_i & (w_cnt_nxt < w_thr);
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        if (w_ok) begin
                            r_n_new <= cfg_div_i;
                            r_state <= S_PEND;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_PEND: begin
                    if (w_apply) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Half-cycle delayed copy of the high phase; ANDing trims half a cycle
    // off the leading edge to give odd ratios a near-50% duty.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) r_hi_n <= 1'b0;
        else       r_hi_n <= r_hi_p;
    end

`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [15:0] r_period_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        r_period_cnt <= '0;
        else if (w_apply) r_period_cnt <= '0;
        else if (r_tick)  r_period_cnt <= r_period_cnt + 16'd1;
    end

    assign period_cnt_o = r_period_cnt;
`else
    // Period counter not built in this configuration.
`endif

    assign cfg_ready_o = r_ready;
    assign cfg_err_o   = r_err;
    assign busy_o      = r_busy;
    assign div_cur_o   = r_div_cur;
    assign tick_o      = r_tick;
    assign clk_div_o   = r_div_cur[0] ? (r_hi_p & r_hi_n) : r_hi_p;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl (DIV_MAX = 200). Inputs change and outputs
// are sampled 1 ns after a clock edge; duty is measured in half-cycle samples.
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       busy;
    logic [7:0] div_cur;
    logic       tick;
    logic       clk_div;
`ifdef CLK_DIV_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int hi;
    int tk;

    always #5 clk = ~clk;

    clk_div_ctrl #(.DIV_W(8), .DIV_DEFAULT(7), .DIV_MAX(200)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .cfg_valid_i (cfg_valid),
        .cfg_div_i   (cfg_div),
        .cfg_ready_o (cfg_ready),
        .cfg_err_o   (cfg_err),
        .busy_o      (busy),
        .div_cur_o   (div_cur),
        .tick_o      (tick),
`ifdef CLK_DIV_PERIOD_CNT_EN
        .period_cnt_o(period_cnt),
`endif
        .clk_div_o   (clk_div)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Counts high half-cycles of clk_div and ticks over ncyc source cycles.
    task automatic measure(input int ncyc, output int h, output int t);
        h = 0;
        t = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk); #1;
            h += int'(clk_div);
            @(posedge clk); #1;
            h += int'(clk_div);
            t += int'(tick);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_div"},   32'(div_cur), 32'd7);
        chk({tag, "_rdy"},   32'(cfg_ready), 32'd1);
        chk({tag, "_err"},   32'(cfg_err), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_tick"},  32'(tick), 32'd0);
        chk({tag, "_clk"},   32'(clk_div), 32'd0);
`ifdef CLK_DIV_PERIOD_CNT_EN
        chk({tag, "_pcnt"},  32'(period_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
        cyc(); cyc();
        chk_reset_outs("rst");

        // Default ratio 7: period 7, high 3.5 cycles.
        rst = 1'b0; en = 1'b1;
        cyc();
        chk("start_tick", 32'(tick), 32'd1);
        chk("start_div",  32'(div_cur), 32'd7);
        measure(14, hi, tk);
        chk("n7_hi_halves", 32'(hi), 32'd14);
        chk("n7_ticks",     32'(tk), 32'd2);
        chk("n7_tick_end",  32'(tick), 32'd1);

        // Offer 4 while cnt_p = 2; change lands after cnt_p = 6.
        cyc(); cyc();
        cfg_valid = 1'b1; cfg_div = 8'd4;
        cyc();
        cfg_valid = 1'b0;
        chk("n4_busy",  32'(busy), 32'd1);
        chk("n4_rdy",   32'(cfg_ready), 32'd0);
        chk("n4_div_a", 32'(div_cur), 32'd7);
        cyc(); cyc(); cyc();
        chk("n4_busy_hold", 32'(busy), 32'd1);
        chk("n4_div_b",     32'(div_cur), 32'd7);
        cyc();
        chk("n4_div_c",  32'(div_cur), 32'd4);
        chk("n4_busy_c", 32'(busy), 32'd0);
        chk("n4_tick_c", 32'(tick), 32'd1);
        chk("n4_clk_c",  32'(clk_div), 32'd1);
        measure(8, hi, tk);
        chk("n4_hi_halves", 32'(hi), 32'd8);
        chk("n4_ticks",     32'(tk), 32'd2);

        // Out-of-range offers: 1, 0, 201.
        cfg_valid = 1'b1; cfg_div = 8'd1;
        cyc();
        cfg_valid = 1'b0;
        chk("err1_pulse", 32'(cfg_err), 32'd1);
        chk("err1_busy",  32'(busy), 32'd0);
        chk("err1_div",   32'(div_cur), 32'd4);
        cyc();
        chk("err1_clear", 32'(cfg_err), 32'd0);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        cyc();
        cfg_valid = 1'b0;
        chk("err0_pulse", 32'(cfg_err), 32'd1);
        cyc();
        chk("err0_clear", 32'(cfg_err), 32'd0);
        cfg_valid = 1'b1; cfg_div = 8'd201;
        cyc();
        cfg_valid = 1'b0;
        chk("err201_pulse", 32'(cfg_err), 32'd1);
        chk("err201_div",   32'(div_cur), 32'd4);
        chk("err201_busy",  32'(busy), 32'd0);
        cyc();
        chk("err201_clear", 32'(cfg_err), 32'd0);

        // Offer 2 (cnt_p = 2), then hold 9 during PEND.
        cfg_valid = 1'b1; cfg_div = 8'd2;
        cyc();
        cfg_div = 8'd9;
        chk("n2_busy", 32'(busy), 32'd1);
        cyc();
        chk("n2_div",   32'(div_cur), 32'd2);
        chk("n2_rdy",   32'(cfg_ready), 32'd1);
        chk("n2_clk_h", 32'(clk_div), 32'd1);
        cyc();
        cfg_valid = 1'b0;
        chk("n9_busy",  32'(busy), 32'd1);
        chk("n9_div_a", 32'(div_cur), 32'd2);
        chk("n2_clk_l", 32'(clk_div), 32'd0);
        cyc();
        chk("n9_div", 32'(div_cur), 32'd9);
        chk("n9_tick", 32'(tick), 32'd1);
        measure(9, hi, tk);
        chk("n9_hi_halves", 32'(hi), 32'd9);
        chk("n9_ticks",     32'(tk), 32'd1);

        // Disable while 5 is pending.
        cfg_valid = 1'b1; cfg_div = 8'd5;
        cyc();
        cfg_valid = 1'b0;
        chk("dis_busy",   32'(busy), 32'd1);
        chk("dis_clk_hi", 32'(clk_div), 32'd1);
        en = 1'b0;
        cyc();
        chk("dis_div",  32'(div_cur), 32'd5);
        chk("dis_busy0", 32'(busy), 32'd0);
        chk("dis_clk",  32'(clk_div), 32'd0);
        chk("dis_tick", 32'(tick), 32'd0);
        cyc();
        chk("dis_clk2", 32'(clk_div), 32'd0);
        en = 1'b1;
        cyc();
        chk("reen_tick", 32'(tick), 32'd1);
        measure(5, hi, tk);
        chk("n5_hi_halves", 32'(hi), 32'd5);
        chk("n5_ticks",     32'(tk), 32'd1);

        // Asynchronous reset while 3 is pending.
        cfg_valid = 1'b1; cfg_div = 8'd3;
        cyc();
        cfg_valid = 1'b0;
        chk("pend3_busy", 32'(busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk_reset_outs("arst");
        cyc();
        rst = 1'b0;

        // Equal ratio still passes through PEND; output unchanged.
        cyc();
        chk("eq_tick", 32'(tick), 32'd1);
        cfg_valid = 1'b1; cfg_div = 8'd7;
        cyc();
        cfg_valid = 1'b0;
        chk("eq_busy", 32'(busy), 32'd1);
        measure(14, hi, tk);
        chk("eq_hi_halves", 32'(hi), 32'd14);
        chk("eq_ticks",     32'(tk), 32'd2);
        chk("eq_busy_end",  32'(busy), 32'd0);
        chk("eq_div",       32'(div_cur), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
